// File: rtl/dmem_arb_pkg.sv
// rtl/dmem_arb_pkg.sv - shared types and defaults for the data-memory arbiter
package dmem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    ACK    = 2'd2
  } state_t;

  localparam int NREQ_DEF = 2;
  localparam int AW_DEF   = 32;
  localparam int DW_DEF   = 32;

  // Last-grant pointer after reset: the highest index, so requester 0 wins first.
  function automatic int last_rst(input int nreq);
    return nreq - 1;
  endfunction

endpackage

// File: rtl/dmem_arbiter_rr_picker.sv
// rtl/dmem_arbiter_rr_picker.sv - combinational round-robin select
// Searches last+1, last+2, ... (mod NREQ) and returns the first asserted request.
module rr_picker #(
  parameter int NREQ = 2,
  parameter int IW   = 1
) (
  input  logic [NREQ-1:0] i_req,
  input  logic [IW-1:0]   i_last,
  output logic [IW-1:0]   o_grant,
  output logic            o_valid
);

  logic [IW-1:0] w_cand;

  // Walk from farthest to nearest so the nearest hit is the one left standing.
  always_comb begin
    o_grant = '0;
    o_valid = 1'b0;
    w_cand  = '0;
    for (int k = NREQ; k >= 1; k--) begin
      w_cand = IW'((int'(i_last) + k) % NREQ);
      if (i_req[w_cand]) begin
        o_grant = w_cand;
        o_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - round-robin arbiter for the single-port data memory
// Serialises requester accesses into fixed 3-cycle grant/access/ack transactions.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int NREQ = NREQ_DEF,
  parameter int AW   = AW_DEF,
  parameter int DW   = DW_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NREQ-1:0]  req,
  input  logic [NREQ-1:0]  req_we,
  input  logic [NREQ*AW-1:0] req_adr,
  input  logic [NREQ*DW-1:0] req_wdata,
  output logic [NREQ-1:0]  ack,
  output logic [DW-1:0]    rdata,
  output logic             err,
  output logic [AW-1:0]    mem_adr,
  output logic [DW-1:0]    mem_Datain,
  output logic             mem_mread,
  output logic             mem_mwrite,
  input  logic [DW-1:0]    mem_Dataout
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  state_t        r_state;
  state_t        w_next;
  logic [IW-1:0] r_sel;
  logic [IW-1:0] r_last;
  logic          r_we;
  logic          r_mis;
  logic [AW-1:0] r_adr;
  logic [DW-1:0] r_wdata;
  logic [DW-1:0] r_rdata;
  logic          r_err;

  logic [IW-1:0] w_grant;
  logic          w_valid;
  logic          w_gnt_we;
  logic [AW-1:0] w_gnt_adr;
  logic [DW-1:0] w_gnt_wdata;

  rr_picker #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_picker (
    .i_req   (req),
    .i_last  (r_last),
    .o_grant (w_grant),
    .o_valid (w_valid)
  );

  assign w_gnt_we    = req_we[w_grant];
  assign w_gnt_adr   = req_adr[int'(w_grant)*AW +: AW];
  assign w_gnt_wdata = req_wdata[int'(w_grant)*DW +: DW];

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next     = r_state;
    ack        = '0;
    mem_adr    = '0;
    mem_Datain = '0;
    mem_mread  = 1'b0;
    mem_mwrite = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_valid) w_next = ACCESS;
      end
      ACCESS: begin
        mem_adr    = r_adr;
        mem_Datain = r_wdata;
        mem_mread  = ~r_mis & ~r_we;
        // Gated by rst so a reset landing mid-access never commits a write.
        mem_mwrite = ~r_mis & r_we & ~rst;
        w_next     = ACK;
      end
      ACK: begin
        ack[r_sel] = 1'b1;
        w_next     = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sel   <= '0;
      r_last  <= IW'(last_rst(NREQ));
      r_we    <= 1'b0;
      r_mis   <= 1'b0;
      r_adr   <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
      r_err   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_valid) begin
            r_sel   <= w_grant;
            r_we    <= w_gnt_we;
            r_adr   <= w_gnt_adr;
            r_wdata <= w_gnt_wdata;
            r_mis   <= (w_gnt_adr[1:0] != 2'b00);
          end
        end
        ACCESS: begin
          r_rdata <= (!r_mis && !r_we) ? mem_Dataout : '0;
          r_err   <= r_mis;
        end
        ACK: begin
          r_last <= r_sel;
          r_err  <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign rdata = r_rdata;
  assign err   = r_err;

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Round-robin arbiter that shares the single-port data memory (byte-addressed, 32-bit little-endian words, combinational read, write on rising clock) between NREQ requesters, e.g. the CPU load/store unit and a DMA/loader port. It sits between the requesters and the memory, serialises their accesses, registers read data and returns a one-cycle acknowledge per transaction. Misaligned word accesses are rejected with an error and never reach the memory.

## Interface
Parameters:
- NREQ, 2, number of requesters (2..8)
- AW, 32, address width (byte address)
- DW, 32, data width

Ports:
- clk  in  1  system clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- req  in  NREQ  per-requester access request, held until that requester's ack
- req_we  in  NREQ  1 = write, 0 = read; stable while req high
- req_adr  in  NREQ*AW  packed byte addresses, requester i at [i*AW +: AW]
- req_wdata  in  NREQ*DW  packed write data
- ack  out  NREQ  one-hot, single-cycle completion strobe
- rdata  out  DW  registered read data, valid while ack high on a read
- err  out  1  high with ack when the access was misaligned
- mem_adr  out  AW  memory address
- mem_Datain  out  DW  memory write data
- mem_mread  out  1  memory read enable
- mem_mwrite  out  1  memory write enable
- mem_Dataout  in  DW  memory read data (combinational)

## Operation
- FSM states IDLE, ACCESS, ACK. Reset: state IDLE, ack 0, err 0, rdata 0, mem_mread 0, mem_mwrite 0, mem_adr 0, mem_Datain 0, last-grant pointer = NREQ-1 (requester 0 wins first).
- IDLE: if any req, pick the first asserted index searching last+1, last+2, ... mod NREQ; latch sel, we, adr, wdata; misaligned = adr[1:0] != 0. Go ACCESS. No req: stay IDLE.
- ACCESS: drive mem_adr/mem_Datain from latches. Aligned: mem_mread = ~we, mem_mwrite = we. Misaligned: both 0. At the closing edge capture rdata = mem_Dataout for aligned reads, else rdata = 0; err = misaligned; go ACK.
- ACK: ack[sel] = 1, all other ack bits 0; last = sel; mem_mread and mem_mwrite 0; go IDLE.
- Requester drops or changes req on the edge that closes its ACK cycle; a req still high is re-sampled in IDLE as a new access.
- req dropped before ack: transaction still completes, ack is issued anyway.
- Write data and address come only from latches; changes on req_* after grant have no effect.

## Timing
- Fixed 3-cycle transaction: grant edge (IDLE->ACCESS), memory edge (ACCESS->ACK, write committed, read captured), ack cycle. Throughput one access per 3 cycles.
- Request seen in IDLE at edge n: ack high during cycle n+2 (counting cycles after edge n).
- mem_mwrite is gated combinationally with ~rst: rst high during ACCESS performs no write; next state IDLE with reset values.
- Two requesters continuously requesting alternate strictly; one requester alone is granted every 3 cycles.
- Simultaneous new requests during ACCESS/ACK are ignored until the next IDLE.

## Structure
- Package dmem_arb_pkg: state enum (IDLE, ACCESS, ACK), width defaults, reset pointer constant.
- Sub-module rr_picker: combinational round-robin select (inputs req and last; outputs grant index and valid).

## Test plan
- Reset: hold rst 2 cycles -> all outputs 0, state IDLE; first req from 0 and 1 together -> ack[0] first.
- Write/read: req0 write adr 0x10 data 0xDEADBEEF -> mem_mwrite exactly 1 cycle; then req0 read 0x10 -> rdata 0xDEADBEEF with ack[0], err 0.
- Fairness: req0 and req1 both held for 12 cycles -> ack sequence 0,1,0,1 at 3-cycle spacing.
- Misaligned: req1 read adr 0x13 -> ack[1] with err 1, rdata 0, mem_mread and mem_mwrite never high.
- Reset mid-op: rst asserted during ACCESS of a write to 0x20 -> mem[0x20..0x23] unchanged, no ack, IDLE next cycle.
- Early drop: req0 deasserted during ACCESS -> ack[0] still pulses once, no second grant.
